// File: rtl/sec_countdown_pkg.sv
// sec_countdown_pkg: shared FSM state type, default count limit,
// and the binary-to-BCD split used for the seven-segment digits.
package sec_countdown_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int MAX_SEC_DEF = 99;

    // {tens, ones} of a value in 0..99
    function automatic logic [7:0] bcd_split(input logic [7:0] v);
        return {4'(v / 8'd10), 4'(v % 8'd10)};
    endfunction

endpackage

// File: rtl/sec_countdown_tick_sync.sv
// tick_sync: 2-flop synchroniser plus edge-history flop; turns each
// rising edge of async_in into one rawClk-wide tick.
// Ports: rawClk, rst_n (async low) in; async_in in;
//        tick (1-cycle pulse), sync (synchronised level) out.
module tick_sync (
    input  logic rawClk,
    input  logic rst_n,
    input  logic async_in,
    output logic tick,
    output logic sync
);

    logic s1, s2, s3;

    always_ff @(posedge rawClk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= async_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign tick = s2 & ~s3;
    assign sync = s2;

endmodule

// File: rtl/sec_countdown.sv
// sec_countdown: loadable seconds countdown paced by the synchronised
// rising edges of slow_clk; drives BCD digits and done/timeout flags.
// Ports: rawClk, rst_n, slow_clk, clear, load, load_val, start, pause in;
//        remain, sec_tens, sec_ones, busy, done, timeout, warn out.
// Optional: define SEC_COUNTDOWN_WARN_EN for the last-seconds warn blink.
module sec_countdown
    import sec_countdown_pkg::*;
#(
    parameter int MAX_SEC  = MAX_SEC_DEF,
    parameter int CNT_W    = 7,
    parameter int WARN_SEC = 5
) (
    input  logic             rawClk,
    input  logic             rst_n,
    input  logic             slow_clk,
    input  logic             clear,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             start,
    input  logic             pause,
    output logic [CNT_W-1:0] remain,
    output logic [3:0]       sec_tens,
    output logic [3:0]       sec_ones,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic             warn
);

    if (MAX_SEC > 99 || WARN_SEC > MAX_SEC) begin : g_cfg_err
        $error("sec_countdown: bad MAX_SEC/WARN_SEC");
    end

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_SEC);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    logic tick;

`ifdef SEC_COUNTDOWN_WARN_EN
    logic s2;
`else
    logic sync_unused;
`endif

    tick_sync u_sync (
        .rawClk   (rawClk),
        .rst_n    (rst_n),
        .async_in (slow_clk),
        .tick     (tick),
`ifdef SEC_COUNTDOWN_WARN_EN
        .sync     (s2)
`else
        .sync     (sync_unused)
`endif
    );

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] load_sat;
    logic             to_d;
    logic [7:0]       bcd;

    logic do_clr, do_ld, do_start, do_pause, do_tick;

    assign load_sat = (load_val > MAX_C) ? MAX_C : load_val;

    // Mutually exclusive command decode, priority clear > load > start > pause.
    // start/pause that are ignored in the current state do not block a tick.
    assign do_clr   = clear;
    assign do_ld    = load & ~clear;
    assign do_start = start & ~clear & ~load &
                      (state_q == IDLE || state_q == PAUSE);
    assign do_pause = pause & ~clear & ~load & (state_q == RUN);
    assign do_tick  = tick & ~clear & ~load & ~pause & (state_q == RUN);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        to_d    = 1'b0;
        unique case (1'b1)
            do_clr: begin
                state_d = IDLE;
                count_d = '0;
            end
            do_ld: begin
                state_d = IDLE;
                count_d = load_sat;
            end
            do_start: begin
                if (count_q != '0)
                    state_d = RUN;
            end
            do_pause: begin
                state_d = PAUSE;
            end
            do_tick: begin
                if (count_q > ONE) begin
                    count_d = count_q - ONE;
                end else begin
                    count_d = '0;
                    state_d = DONE;
                    to_d    = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign bcd = bcd_split(8'(count_d));

    always_ff @(posedge rawClk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            sec_tens <= 4'd0;
            sec_ones <= 4'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            sec_tens <= bcd[7:4];
            sec_ones <= bcd[3:0];
            busy     <= (state_d == RUN) || (state_d == PAUSE);
            done     <= (state_d == DONE);
            timeout  <= to_d;
        end
    end

    assign remain = count_q;

`ifdef SEC_COUNTDOWN_WARN_EN
    localparam logic [CNT_W-1:0] WARN_C = CNT_W'(WARN_SEC);
    logic low;
    assign low  = (count_q <= WARN_C);
    // Blinks in phase with slow_clk while running, steady while paused.
    assign warn = low & (((state_q == RUN) & s2) | (state_q == PAUSE));
`else
    assign warn = 1'b0;
`endif

endmodule

// File: tb/tb_sec_countdown.sv
// tb_sec_countdown: directed vectors for sec_countdown with
// hand-computed expectations and a single comparison task.
module tb_sec_countdown;

    logic       rawClk = 1'b0;
    logic       rst_n = 1'b0;
    logic       slow_clk = 1'b0;
    logic       clear = 1'b0;
    logic       load = 1'b0;
    logic [6:0] load_val = 7'd0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic [6:0] remain;
    logic [3:0] sec_tens, sec_ones;
    logic       busy, done, timeout, warn;

    int n_cmp = 0;
    int n_bad = 0;

    sec_countdown dut (
        .rawClk   (rawClk),
        .rst_n    (rst_n),
        .slow_clk (slow_clk),
        .clear    (clear),
        .load     (load),
        .load_val (load_val),
        .start    (start),
        .pause    (pause),
        .remain   (remain),
        .sec_tens (sec_tens),
        .sec_ones (sec_ones),
        .busy     (busy),
        .done     (done),
        .timeout  (timeout),
        .warn     (warn)
    );

    always #5 rawClk = ~rawClk;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge rawClk);
        #1;
    endtask

    task automatic pulse();
        slow_clk = 1'b1;
        repeat (3) step();
        slow_clk = 1'b0;
        repeat (3) step();
    endtask

    task automatic do_load(input int v);
        load = 1'b1;
        load_val = 7'(v);
        step();
        load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    int exp_w;

    initial begin
        // reset state
        repeat (2) step();
        chk("rst_remain", remain, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst_n = 1'b1;
        step();

        // 3-second countdown with exact timeout pulse
        do_load(3);
        chk("ld3_remain", remain, 3);
        do_start();
        chk("ld3_busy", busy, 1);
        pulse();
        chk("cd_2", remain, 2);
        pulse();
        chk("cd_1", remain, 1);
        slow_clk = 1'b1;
        step();
        step();
        chk("cd_pre_to", timeout, 0);
        step();
        chk("cd_0", remain, 0);
        chk("cd_to", timeout, 1);
        chk("cd_done", done, 1);
        chk("cd_ones", sec_ones, 0);
        chk("cd_busy", busy, 0);
        step();
        chk("cd_to_off", timeout, 0);
        chk("cd_done_hold", done, 1);
        slow_clk = 1'b0;
        repeat (3) step();

        // saturation to 99
        do_load(120);
        chk("sat_remain", remain, 99);
        chk("sat_tens", sec_tens, 9);
        chk("sat_ones", sec_ones, 9);
        chk("sat_done", done, 0);

        // start with zero count stays idle
        do_load(0);
        do_start();
        chk("zero_busy", busy, 0);
        chk("zero_remain", remain, 0);

        // pause / resume
        do_load(10);
        chk("p_tens", sec_tens, 1);
        chk("p_ones", sec_ones, 0);
        do_start();
        pulse();
        pulse();
        chk("p_8", remain, 8);
        pause = 1'b1;
        step();
        pause = 1'b0;
        pulse();
        pulse();
        pulse();
        chk("p_hold", remain, 8);
        chk("p_busy", busy, 1);
        do_start();
        pulse();
        chk("p_7", remain, 7);
        chk("p_7_ones", sec_ones, 7);

        // start coincident with tick
        do_load(5);
        slow_clk = 1'b1;
        step();
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("st_tick_rem", remain, 5);
        chk("st_tick_busy", busy, 1);
        slow_clk = 1'b0;
        repeat (3) step();
        pulse();
        chk("st_tick_next", remain, 4);

        // clear and load in the same cycle
        clear = 1'b1;
        load = 1'b1;
        load_val = 7'd42;
        step();
        clear = 1'b0;
        load = 1'b0;
        chk("cl_ld_rem", remain, 0);
        chk("cl_ld_busy", busy, 0);

        // load during RUN at remain=1 coincident with tick
        do_load(2);
        do_start();
        pulse();
        chk("lr_1", remain, 1);
        slow_clk = 1'b1;
        step();
        step();
        load = 1'b1;
        load_val = 7'd9;
        step();
        load = 1'b0;
        chk("lr_rem", remain, 9);
        chk("lr_to", timeout, 0);
        chk("lr_done", done, 0);
        chk("lr_busy", busy, 0);
        step();
        chk("lr_to2", timeout, 0);
        slow_clk = 1'b0;
        repeat (3) step();

        // warn behaviour
`ifdef SEC_COUNTDOWN_WARN_EN
        exp_w = 1;
`else
        exp_w = 0;
`endif
        do_load(7);
        do_start();
        slow_clk = 1'b1;
        repeat (3) step();
        chk("w_6_rem", remain, 6);
        chk("w_6_hi", warn, 0);
        slow_clk = 1'b0;
        repeat (3) step();
        slow_clk = 1'b1;
        repeat (3) step();
        chk("w_5_rem", remain, 5);
        chk("w_5_hi", warn, exp_w);
        slow_clk = 1'b0;
        repeat (3) step();
        chk("w_5_lo", warn, 0);

        // async reset mid-run
        do_load(7);
        do_start();
        chk("ar_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_remain", remain, 0);
        chk("ar_busy0", busy, 0);
        chk("ar_tens", sec_tens, 0);
        chk("ar_ones", sec_ones, 0);
        step();
        rst_n = 1'b1;
        step();
        chk("ar_post_rem", remain, 0);
        do_start();
        chk("ar_post_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sec_countdown.md
Name: sec_countdown

Overview:
- Consumer end of the divided-clock path: takes the slow square wave produced by the 1 s divider as a data input.
- Runs it through a 2-flop synchroniser in the rawClk domain and turns each rising edge into a single-cycle tick.
- Uses the tick to run a loadable seconds countdown (vending-machine purchase/refund timeout).
- Drives BCD digits for the seven-segment display plus done/timeout flags to the control FSM.

Parameters:
- MAX_SEC, 99, largest loadable count. Loads above this saturate to MAX_SEC. Must be ≤ 99 for BCD output.
- CNT_W, 7, width of load_val and remain.
- WARN_SEC, 5, warning threshold; used only with the optional feature.

Ports:
- rawClk  in  1  system clock (100 MHz)
- rst_n  in  1  asynchronous active-low reset
- slow_clk  in  1  divided 1 s square wave; treated as asynchronous data, never used as a clock
- clear  in  1  abort, return to IDLE, count := 0
- load  in  1  capture load_val into count
- load_val  in  CNT_W  seconds to load
- start  in  1  begin or resume counting
- pause  in  1  hold count
- remain  out  CNT_W  current count (binary)
- sec_tens  out  4  BCD tens of remain
- sec_ones  out  4  BCD ones of remain
- busy  out  1  high in RUN or PAUSE
- done  out  1  level, high in DONE
- timeout  out  1  one-cycle pulse on entry to DONE
- warn  out  1  see Optional Feature; tied 0 when the feature is compiled out

Behaviour:
- Reset (async, rst_n=0): synchroniser flops 0, edge-history flop 0, count 0, state IDLE, all outputs 0.
- Tick generation:
  - s1 <= slow_clk; s2 <= s1; s3 <= s2; tick = s2 & ~s3.
  - tick is high exactly one rawClk cycle, 2–3 cycles after a slow_clk rise.
  - Falling edges are ignored.
- State encoding: IDLE=0, RUN=1, PAUSE=2, DONE=3, registered.
- Command priority per cycle: clear > load > start > pause.
  - clear, any state: count := 0, go to IDLE.
  - load, any state: count := min(load_val, MAX_SEC), go to IDLE. A running countdown is aborted and no timeout is generated.
  - start in IDLE or PAUSE: count ≠ 0 → RUN; count = 0 → stay, no action. start in RUN or DONE is ignored.
  - pause in RUN → PAUSE. pause in any other state is ignored.
- RUN counting:
  - On a tick with count > 1: count := count − 1.
  - On a tick with count = 1: count := 0, go to DONE, timeout = 1 for that cycle.
- Ticks in IDLE, PAUSE and DONE are ignored.
- A tick in the same cycle as start is not applied; the first decrement happens on the next tick. A tick in the same cycle as pause is not applied.
- DONE holds until clear or load.
- Output timing:
  - remain, sec_tens and sec_ones are registered and update in the cycle after count changes.
  - sec_tens = remain/10, sec_ones = remain%10, computed combinationally from count and then registered.
  - busy, done and timeout are registered; latency from the triggering cycle is 1 cycle.
- count never wraps below 0 and never exceeds MAX_SEC.

Optional Feature:
- Macro: SEC_COUNTDOWN_WARN_EN.
- Defined:
  - warn = 1 when state = RUN and remain ≤ WARN_SEC.
  - While in RUN, warn also toggles phase with s2, so it follows slow_clk: high during the high half-second and low during the low half-second. This blinks the display in the last seconds.
  - warn = 1 steadily in PAUSE when remain ≤ WARN_SEC.
  - warn = 0 otherwise.
- Undefined: warn tied 0. No extra logic.

Decomposition:
- Package sec_countdown_pkg holds:
  - state localparams (IDLE/RUN/PAUSE/DONE, 2-bit)
  - default MAX_SEC
  - the BCD split helper function
- Sub-module tick_sync (rawClk, rst_n, async_in → tick): the 3-flop sync plus rising-edge pulse. It is reusable for other slow enables in the codebase.

Test Plan:
- Reset mid-RUN (count=7): assert rst_n=0 → all outputs 0 immediately; after release, state IDLE, remain=0.
- load_val=3, start, three slow_clk rises → remain 3→2→1→0; timeout pulses exactly 1 cycle on the third tick; done=1; sec_ones=0.
- load_val=120 → remain=99, sec_tens=9, sec_ones=9. load_val=0 then start → stays IDLE, busy=0.
- load 10, start, 2 ticks, pause, 3 ticks, start, 1 tick → remain goes 10→8, holds 8 through the paused ticks, then 7.
- Same-cycle events:
  - start coincident with tick → no decrement.
  - clear and load in the same cycle → remain=0, IDLE.
  - load during RUN with remain=1 just before a tick → no timeout; remain=load_val.
- With SEC_COUNTDOWN_WARN_EN, load 7, start → warn stays 0 until remain=5, then follows slow_clk. Without the macro, warn=0 throughout.
